disp8_bcd_scan: RTL and testbench
=================================

DISP8_BCD_SCAN -- requirements
Module: disp8_bcd_scan

Interface
REQ-001 Parameter PRESC, default 50000: clocks per digit-scan step; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 shows all eight digits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 Ddec  input  32  packed BCD from the binary-to-decimal converter; nibble k is digit k, digit 0 is least significant.
REQ-007 ptr_dig  input  4  converter digit pointer; value 0 means conversion finished and Ddec stable.
REQ-008 dp_en  input  8  per-digit decimal point request; bit k lights the point of digit k.
REQ-009 AN  output  8  digit anode enables, active-low, one-hot-zero.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point segment, active-low.
REQ-012 upd  output  1  one-cycle pulse, high in the cycle after a new Ddec value is captured.

Function
REQ-013 done SHALL be (ptr_dig==0); done_q SHALL be done registered every cycle.
REQ-014 The block SHALL capture Ddec into a 32-bit display latch on the cycle where done & !done_q; upd SHALL be high the next cycle.
REQ-015 While ptr_dig!=0 the display latch SHALL hold, so the display keeps the previous result for the whole conversion.
REQ-016 A 20-bit prescaler SHALL count 0..PRESC-1 and wrap; tick SHALL be high in the cycle the count equals PRESC-1.
REQ-017 A 3-bit scan index SHALL increment on tick and wrap from 7 to 0.
REQ-018 AN, seg and dp SHALL be registered; they reflect the scan index and latch contents with one cycle of latency.
REQ-019 AN SHALL drive low only bit [scan index]; all other bits high.
REQ-020 Digit decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 A latched nibble of 10..15 SHALL display a dash (seg=0111111) and SHALL count as non-zero for blanking.
REQ-022 With BLANK_LZ=1, digit k (k>=1) SHALL be blanked (seg=1111111, dp=1) iff every latched nibble j>=k is 0 and dp_en[j]=0 for every j>=k.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 dp SHALL be !dp_en[k] for the displayed digit k unless that digit is blanked; dp_en is sampled live, not latched.
REQ-025 A simultaneous tick and capture SHALL both take effect; the new scan index uses the new latch value at the next output update.
REQ-026 AN SHALL remain driven during capture; no blank cycle is inserted.

Reset
REQ-027 On rst: display latch=0, done_q=1, prescaler=0, scan index=0, upd=0, AN=8'hFF, seg=7'h7F, dp=1.
REQ-028 done_q=1 at reset SHALL suppress a capture when ptr_dig is already 0 after reset.
REQ-029 The first cycle after rst deasserts SHALL drive AN=8'hFE, seg=1000000 (digit 0 shows "0"), dp=!dp_en[0].
REQ-030 rst asserted mid-conversion or mid-scan SHALL override all other activity in that cycle.

Verification (PRESC=4, BLANK_LZ=1)
REQ-031 rst 1 cycle, ptr_dig=0, dp_en=0 -> AN=FF during rst; afterwards AN=FE, seg=1000000, upd never pulses; digits 1..7 show seg=1111111 while their anodes are active.
REQ-032 ptr_dig 8->...->1->0 with Ddec=32'h00012345 -> upd one pulse; the scan shows digits 0..4 as 5,4,3,2,1 and digits 5..7 blank; AN walks FE,FD,...,7F every 4 clocks.
REQ-033 Ddec changes while ptr_dig=5 -> display keeps the prior value until ptr_dig returns to 0.
REQ-034 Latch 32'h00000005 with dp_en=8'h04 -> digits 2,1 show "0", digit 2 dp=0, digit 0 shows 5, digits 3..7 blank.
REQ-035 Latch 32'h0000A000 -> digit 3 shows dash; digits 2..0 show "0"; digits 7..4 blank.
REQ-036 rst pulsed during scan index 5 -> next cycle AN=FE and the latch is 0.

Source files
------------

// File: rtl/disp8_bcd_scan.sv
// rtl/disp8_bcd_scan.sv - eight-digit multiplexed 7-segment display for a BCD result
// Latches a finished conversion and time-multiplexes it onto active-low anodes/segments.
module disp8_bcd_scan #(
  parameter int PRESC    = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Ddec,
  input  logic [3:0]  ptr_dig,
  input  logic [7:0]  dp_en,
  output logic [7:0]  AN,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        upd
);

  localparam logic [19:0] LP_PRESC_TOP = 20'(PRESC - 1);

  logic        r_done_q;
  logic [31:0] r_latch;
  logic [19:0] r_presc;
  logic [2:0]  r_scan;
  logic        r_upd;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_done;
  logic        w_capture;
  logic        w_tick;
  logic [7:0]  w_keep;
  logic        w_acc;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_dec;

  assign w_done    = (ptr_dig == 4'd0);
  assign w_capture = w_done & ~r_done_q;
  assign w_tick    = (r_presc == LP_PRESC_TOP);

  // Latch / conversion tracking; the latch only moves on the rising edge of done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q <= 1'b1;
      r_latch  <= 32'd0;
      r_upd    <= 1'b0;
    end else begin
      r_done_q <= w_done;
      r_upd    <= w_capture;
      if (w_capture) begin
        r_latch <= Ddec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= 20'd0;
      r_scan  <= 3'd0;
    end else begin
      if (w_tick) begin
        r_presc <= 20'd0;
        r_scan  <= r_scan + 3'd1;
      end else begin
        r_presc <= r_presc + 20'd1;
      end
    end
  end

  // w_keep[k]: some nibble or point at or above digit k is lit, so digit k must show
  always_comb begin
    w_keep = 8'd0;
    w_acc  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      w_acc     = w_acc | (r_latch[4*k +: 4] != 4'd0) | dp_en[k];
      w_keep[k] = w_acc;
    end
    w_keep[0] = 1'b1;
    if (BLANK_LZ == 0) begin
      w_keep = 8'hFF;
    end
  end

  assign w_nib   = r_latch[{r_scan, 2'b00} +: 4];
  assign w_blank = ~w_keep[r_scan];

  always_comb begin
    w_seg_dec = 7'b0111111;
    case (w_nib)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'd1 << r_scan);
      r_seg <= w_blank ? 7'h7F : w_seg_dec;
      r_dp  <= w_blank ? 1'b1 : ~dp_en[r_scan];
    end
  end

  assign AN  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
  assign upd = r_upd;

endmodule

// File: tb/tb_disp8_bcd_scan.sv
// tb/tb_disp8_bcd_scan.sv - randomized self-checking bench for disp8_bcd_scan
// Reference model: display value, conversion state and elapsed clocks since reset.
module tb_disp8_bcd_scan;

  localparam int PRESC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Ddec;
  logic [3:0]  ptr_dig;
  logic [7:0]  dp_en;
  logic [7:0]  AN;
  logic [6:0]  seg;
  logic        dp;
  logic        upd;

  disp8_bcd_scan #(.PRESC(PRESC), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .Ddec(Ddec), .ptr_dig(ptr_dig), .dp_en(dp_en),
    .AN(AN), .seg(seg), .dp(dp), .upd(upd)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_shown;
  logic        m_in_conv;
  int          m_clocks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] digit_val(input logic [31:0] v, input int k);
    return (v >> (4 * k)) & 32'hF;
  endfunction

  // One clock: predict outputs from the model, clock, update the model, check.
  task automatic run_cycle();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_upd;
    int         k;
    int         nib;
    bit         blank;
    if (rst) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_upd = 1'b0;
    end else begin
      k     = (m_clocks / PRESC) % 8;
      e_an  = ~(8'd1 << k);
      blank = (k >= 1);
      for (int j = k; j <= 7; j++) begin
        if (digit_val(m_shown, j) != 0 || dp_en[j]) blank = 0;
      end
      nib   = int'(digit_val(m_shown, k));
      e_seg = blank ? 7'h7F : (nib > 9 ? 7'b0111111 : seg_tbl[nib]);
      e_dp  = blank ? 1'b1 : ~dp_en[k];
      e_upd = (ptr_dig == 0) && m_in_conv;
    end
    @(posedge clk);
    if (rst) begin
      m_shown = 32'd0; m_in_conv = 1'b0; m_clocks = 0;
    end else begin
      if (ptr_dig == 0 && m_in_conv) m_shown = Ddec;
      m_in_conv = (ptr_dig != 0);
      m_clocks++;
    end
    @(negedge clk);
    chk("AN", 32'(AN), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("upd", 32'(upd), 32'(e_upd));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) run_cycle();
    rst = 1'b0;
  endtask

  task automatic convert(input logic [31:0] val, input int hold, input bit jitter);
    for (int p = 8; p >= 1; p--) begin
      ptr_dig = 4'(p);
      Ddec    = $urandom;
      repeat (1 + $urandom_range(0, 1)) run_cycle();
    end
    ptr_dig = 4'd0;
    Ddec    = val;
    for (int i = 0; i < hold; i++) begin
      run_cycle();
      if (jitter && $urandom_range(0, 7) == 0) Ddec = $urandom;
      if (jitter && $urandom_range(0, 15) == 0) dp_en = 8'(1 << $urandom_range(0, 7));
    end
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int          nd;
    v  = 32'd0;
    nd = $urandom_range(0, 8);
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1; Ddec = 32'd0; ptr_dig = 4'd0; dp_en = 8'd0;
    m_shown = 32'd0; m_in_conv = 1'b0; m_clocks = 0;
    @(negedge clk);

    do_reset(1);
    repeat (40) run_cycle();

    convert(32'h00012345, 40, 1'b0);
    ptr_dig = 4'd5;
    repeat (6) begin Ddec = $urandom; run_cycle(); end
    ptr_dig = 4'd0; Ddec = 32'h00000005; dp_en = 8'h04;
    repeat (40) run_cycle();
    convert(32'h0000A000, 36, 1'b0);
    dp_en = 8'h00;

    while (((m_clocks / PRESC) % 8) != 5) run_cycle();
    run_cycle();
    do_reset(1);
    repeat (10) run_cycle();

    for (int t = 0; t < 30; t++) begin
      dp_en = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      convert(rand_bcd(), $urandom_range(2, 40), 1'b1);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
    end
    ptr_dig = 4'd3;
    repeat (3) run_cycle();
    do_reset(1);
    ptr_dig = 4'd0;
    repeat (10) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
